// File: rtl/noc_input_port.sv
// noc_input_port: router input stage. Buffers flits arriving over the link in
// a DEPTH-entry circular FIFO, computes an XY route from each head flit, holds
// a switch request for the whole packet and returns one credit per flit drained.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_i/valid_i  flit from the upstream output port
//   credit_o        registered one-cycle credit pulse per pop (incl. drops)
//   req_o           registered one-hot output request {W,S,E,N,Local}
//   grant_i         switch grant for req_o, held until release_o
//   out_ready_i     granted output accepts a flit this cycle
//   data_o          FIFO head flit
//   flit_valid_o    data_o is popped to the switch this cycle (combinational)
//   release_o       tail flit pops this cycle (combinational)
//   error_o         sticky protocol error (overflow or headless body/tail)
module noc_input_port #(
    parameter int unsigned DEPTH = 5,
    parameter logic [2:0]  MY_X  = 3'd0,
    parameter logic [2:0]  MY_Y  = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        credit_o,
    output logic [4:0]  req_o,
    input  logic        grant_i,
    input  logic        out_ready_i,
    output logic [15:0] data_o,
    output logic        flit_valid_o,
    output logic        release_o,
    output logic        error_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [4:0] REQ_LOCAL = 5'b00001;
    localparam logic [4:0] REQ_N     = 5'b00010;
    localparam logic [4:0] REQ_E     = 5'b00100;
    localparam logic [4:0] REQ_S     = 5'b01000;
    localparam logic [4:0] REQ_W     = 5'b10000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [4:0]        req_next;
    logic              error_next;
    logic              push_c;
    logic              pop_c;
    logic              empty_c;
    logic              full_c;
    logic [15:0]       head_c;
    logic              head_is_head_c;
    logic              head_is_tail_c;
    logic [2:0]        dest_x_c;
    logic [2:0]        dest_y_c;
    logic [4:0]        route_c;

    // FIFO head decode; type bit 0 marks HEAD/HEAD+TAIL, bit 1 marks TAIL/HEAD+TAIL
    assign head_c         = mem[rd_ptr];
    assign data_o         = head_c;
    assign empty_c        = (count == '0);
    assign full_c         = (count == FULL_CNT);
    assign head_is_head_c = head_c[14];
    assign head_is_tail_c = head_c[15];
    assign dest_x_c       = head_c[13:11];
    assign dest_y_c       = head_c[10:8];

    // XY dimension-order route, X resolved first
    always_comb begin
        route_c = REQ_LOCAL;
        if (dest_x_c > MY_X) begin
            route_c = REQ_E;
        end else if (dest_x_c < MY_X) begin
            route_c = REQ_W;
        end else if (dest_y_c > MY_Y) begin
            route_c = REQ_N;
        end else if (dest_y_c < MY_Y) begin
            route_c = REQ_S;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, pop decision and combinational switch-side outputs
    always_comb begin
        state_next   = state;
        req_next     = req_o;
        error_next   = error_o;
        pop_c        = 1'b0;
        flit_valid_o = 1'b0;
        release_o    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    if (head_is_head_c) begin
                        req_next   = route_c;
                        state_next = REQ;
                    end else begin
                        // Headless body/tail: drop it but still return its credit
                        pop_c      = 1'b1;
                        error_next = 1'b1;
                    end
                end
            end
            REQ: begin
                if (grant_i) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!empty_c && out_ready_i) begin
                    pop_c        = 1'b1;
                    flit_valid_o = 1'b1;
                    if (head_is_tail_c) begin
                        release_o  = 1'b1;
                        req_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A full FIFO still accepts when the same cycle frees a slot
        push_c = valid_i && (!full_c || pop_c);
        if (valid_i && full_c && !pop_c) begin
            error_next = 1'b1;
        end
    end

    // Pointers, occupancy and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            req_o    <= '0;
            credit_o <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            req_o    <= req_next;
            credit_o <= pop_c;
            error_o  <= error_next;
        end
    end

    // Flit storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// tb_noc_input_port: directed self-checking bench for noc_input_port with
// MY_X=1, MY_Y=1, DEPTH=5. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge. Test cycle c starts right after a rising edge.
module tb_noc_input_port;

    logic        clk;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        credit_o;
    logic [4:0]  req_o;
    logic        grant_i;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        flit_valid_o;
    logic        release_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    noc_input_port #(
        .DEPTH(5),
        .MY_X (3'd1),
        .MY_Y (3'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .credit_o    (credit_o),
        .req_o       (req_o),
        .grant_i     (grant_i),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .flit_valid_o(flit_valid_o),
        .release_o   (release_o),
        .error_o     (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        valid_i     = 1'b0;
        data_i      = '0;
        grant_i     = 1'b0;
        out_ready_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (req_o !== 5'b0) begin errors++; $display("FAIL reset_req got=%b exp=00000", req_o); end
        checks++;
        if (credit_o !== 1'b0) begin errors++; $display("FAIL reset_credit got=%b exp=0", credit_o); end
        checks++;
        if (flit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", flit_valid_o); end
        checks++;
        if (release_o !== 1'b0) begin errors++; $display("FAIL reset_release got=%b exp=0", release_o); end
        checks++;
        if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error_o); end
        checks++;
        if (dut.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dut.count); end
        step();
    endtask

    // HEAD(3,1), BODY, TAIL; grant at 3; expect E request and pops 4..6
    task automatic test_basic();
        logic [15:0] f [3];
        logic [4:0]  exp_req;
        logic        exp_fv, exp_rel, exp_cr;
        f[0] = {2'b01, 3'd3, 3'd1, 8'hA1};
        f[1] = {2'b00, 14'h0B01};
        f[2] = {2'b10, 14'h0C02};
        for (int c = 0; c < 10; c++) begin
            valid_i     = (c < 3);
            data_i      = (c < 3) ? f[c] : 16'h0;
            grant_i     = (c >= 3);
            out_ready_i = 1'b1;
            @(negedge clk);
            exp_req = (c >= 2 && c <= 6) ? 5'b00100 : 5'b00000;
            exp_fv  = (c >= 4 && c <= 6);
            exp_rel = (c == 6);
            exp_cr  = (c >= 5 && c <= 7);
            checks++;
            if (req_o !== exp_req) begin errors++; $display("FAIL basic_req c=%0d got=%b exp=%b", c, req_o, exp_req); end
            checks++;
            if (flit_valid_o !== exp_fv) begin errors++; $display("FAIL basic_fv c=%0d got=%b exp=%b", c, flit_valid_o, exp_fv); end
            checks++;
            if (release_o !== exp_rel) begin errors++; $display("FAIL basic_release c=%0d got=%b exp=%b", c, release_o, exp_rel); end
            checks++;
            if (credit_o !== exp_cr) begin errors++; $display("FAIL basic_credit c=%0d got=%b exp=%b", c, credit_o, exp_cr); end
            if (exp_fv) begin
                checks++;
                if (data_o !== f[c-4]) begin errors++; $display("FAIL basic_data c=%0d got=%h exp=%h", c, data_o, f[c-4]); end
            end
            step();
        end
    endtask

    // Single-flit packets to W, N, S and Local
    task automatic test_route();
        logic [2:0] dx [4];
        logic [2:0] dy [4];
        logic [4:0] er [4];
        logic [15:0] flit;
        logic [4:0]  exp_req;
        dx[0] = 3'd0; dy[0] = 3'd1; er[0] = 5'b10000;
        dx[1] = 3'd1; dy[1] = 3'd2; er[1] = 5'b00010;
        dx[2] = 3'd1; dy[2] = 3'd0; er[2] = 5'b01000;
        dx[3] = 3'd1; dy[3] = 3'd1; er[3] = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            flit = {2'b11, dx[i], dy[i], 8'(8'h50 + i)};
            for (int c = 0; c < 6; c++) begin
                valid_i     = (c == 0);
                data_i      = flit;
                grant_i     = 1'b1;
                out_ready_i = 1'b1;
                @(negedge clk);
                exp_req = (c == 2 || c == 3) ? er[i] : 5'b00000;
                checks++;
                if (req_o !== exp_req) begin errors++; $display("FAIL route_req i=%0d c=%0d got=%b exp=%b", i, c, req_o, exp_req); end
                checks++;
                if (flit_valid_o !== (c == 3)) begin errors++; $display("FAIL route_fv i=%0d c=%0d got=%b", i, c, flit_valid_o); end
                checks++;
                if (release_o !== (c == 3)) begin errors++; $display("FAIL route_release i=%0d c=%0d got=%b", i, c, release_o); end
                checks++;
                if (credit_o !== (c == 4)) begin errors++; $display("FAIL route_credit i=%0d c=%0d got=%b", i, c, credit_o); end
                if (c == 3) begin
                    checks++;
                    if (data_o !== flit) begin errors++; $display("FAIL route_data i=%0d got=%h exp=%h", i, data_o, flit); end
                end
                step();
            end
        end
    endtask

    // Fill to 5 with no grant, overflow the 6th, then drain exactly 5
    task automatic test_fill();
        logic [15:0] f [6];
        int credits = 0;
        int pops    = 0;
        int rels    = 0;
        f[0] = {2'b01, 3'd1, 3'd1, 8'h10};
        f[1] = {2'b00, 14'h0011};
        f[2] = {2'b00, 14'h0012};
        f[3] = {2'b00, 14'h0013};
        f[4] = {2'b10, 14'h0014};
        f[5] = {2'b00, 14'h0015};
        for (int c = 0; c < 7; c++) begin
            valid_i     = (c < 6);
            data_i      = (c < 6) ? f[c] : 16'h0;
            grant_i     = 1'b0;
            out_ready_i = 1'b1;
            @(negedge clk);
            checks++;
            if (credit_o !== 1'b0) begin errors++; $display("FAIL fill_credit c=%0d got=%b exp=0", c, credit_o); end
            step();
        end
        @(negedge clk);
        checks++;
        if (dut.count !== 3'd5) begin errors++; $display("FAIL fill_count got=%0d exp=5", dut.count); end
        checks++;
        if (error_o !== 1'b1) begin errors++; $display("FAIL fill_error got=%b exp=1", error_o); end
        step();
        for (int c = 0; c < 14; c++) begin
            valid_i = 1'b0;
            grant_i = 1'b1;
            @(negedge clk);
            if (credit_o === 1'b1) credits++;
            if (release_o === 1'b1) rels++;
            if (flit_valid_o === 1'b1) begin
                if (pops < 5) begin
                    checks++;
                    if (data_o !== f[pops]) begin errors++; $display("FAIL fill_data k=%0d got=%h exp=%h", pops, data_o, f[pops]); end
                end
                pops++;
            end
            step();
        end
        checks++;
        if (credits != 5) begin errors++; $display("FAIL fill_credits got=%0d exp=5", credits); end
        checks++;
        if (pops != 5) begin errors++; $display("FAIL fill_pops got=%0d exp=5", pops); end
        checks++;
        if (rels != 1) begin errors++; $display("FAIL fill_releases got=%0d exp=1", rels); end
    endtask

    // Full FIFO with push+pop every cycle; order kept across pointer wrap
    task automatic test_wrap();
        logic [15:0] g [12];
        int pi = 0;
        int po = 0;
        int rels = 0;
        g[0] = {2'b01, 3'd1, 3'd1, 8'h00};
        for (int k = 1; k < 11; k++) g[k] = {2'b00, 6'd0, 8'(k)};
        g[11] = {2'b10, 6'd0, 8'd11};
        for (int c = 0; c < 22; c++) begin
            if (pi < 12 && (c < 5 || c >= 6)) begin
                valid_i = 1'b1;
                data_i  = g[pi];
                pi++;
            end else begin
                valid_i = 1'b0;
                data_i  = 16'h0;
            end
            grant_i     = (c >= 5);
            out_ready_i = 1'b1;
            @(negedge clk);
            if (c >= 5 && c <= 13) begin
                checks++;
                if (dut.count !== 3'd5) begin errors++; $display("FAIL wrap_count c=%0d got=%0d exp=5", c, dut.count); end
            end
            checks++;
            if (error_o !== 1'b0) begin errors++; $display("FAIL wrap_error c=%0d got=%b exp=0", c, error_o); end
            if (release_o === 1'b1) rels++;
            if (flit_valid_o === 1'b1) begin
                if (po < 12) begin
                    checks++;
                    if (data_o !== g[po]) begin errors++; $display("FAIL wrap_data k=%0d got=%h exp=%h", po, data_o, g[po]); end
                end
                po++;
            end
            step();
        end
        checks++;
        if (po != 12) begin errors++; $display("FAIL wrap_pops got=%0d exp=12", po); end
        checks++;
        if (rels != 1) begin errors++; $display("FAIL wrap_releases got=%0d exp=1", rels); end
    endtask

    // BODY with no packet open: dropped, credited, flagged, no request
    task automatic test_body_idle();
        for (int c = 0; c < 4; c++) begin
            valid_i     = (c == 0);
            data_i      = {2'b00, 14'h0777};
            grant_i     = 1'b0;
            out_ready_i = 1'b1;
            @(negedge clk);
            checks++;
            if (flit_valid_o !== 1'b0) begin errors++; $display("FAIL body_fv c=%0d got=%b exp=0", c, flit_valid_o); end
            checks++;
            if (req_o !== 5'b0) begin errors++; $display("FAIL body_req c=%0d got=%b exp=00000", c, req_o); end
            checks++;
            if (credit_o !== (c == 2)) begin errors++; $display("FAIL body_credit c=%0d got=%b exp=%b", c, credit_o, (c == 2)); end
            checks++;
            if (error_o !== (c >= 2)) begin errors++; $display("FAIL body_error c=%0d got=%b exp=%b", c, error_o, (c >= 2)); end
            step();
        end
    endtask

    // out_ready 1,0,1 gates pops; reset mid-packet discards the remainder
    task automatic test_ready_rst();
        logic [15:0] h [4];
        h[0] = {2'b01, 3'd1, 3'd1, 8'h20};
        h[1] = {2'b00, 14'h0021};
        h[2] = {2'b00, 14'h0022};
        h[3] = {2'b10, 14'h0023};
        for (int c = 0; c < 7; c++) begin
            valid_i     = (c < 4);
            data_i      = (c < 4) ? h[c] : 16'h0;
            grant_i     = (c >= 2);
            out_ready_i = (c == 3 || c == 5);
            rst         = (c == 6);
            if (c == 6) out_ready_i = 1'b0;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (req_o !== 5'b00001) begin errors++; $display("FAIL rr_req got=%b exp=00001", req_o); end
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (flit_valid_o !== (c != 4)) begin errors++; $display("FAIL rr_fv c=%0d got=%b exp=%b", c, flit_valid_o, (c != 4)); end
            end
            if (c == 3) begin
                checks++;
                if (data_o !== h[0]) begin errors++; $display("FAIL rr_data0 got=%h exp=%h", data_o, h[0]); end
            end
            if (c == 5) begin
                checks++;
                if (data_o !== h[1]) begin errors++; $display("FAIL rr_data1 got=%h exp=%h", data_o, h[1]); end
            end
            step();
        end
        rst = 1'b0;
        for (int c = 7; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (req_o !== 5'b0) begin errors++; $display("FAIL rr_post_req c=%0d got=%b exp=00000", c, req_o); end
            checks++;
            if (credit_o !== 1'b0) begin errors++; $display("FAIL rr_post_credit c=%0d got=%b exp=0", c, credit_o); end
            checks++;
            if (error_o !== 1'b0) begin errors++; $display("FAIL rr_post_error c=%0d got=%b exp=0", c, error_o); end
            checks++;
            if (dut.count !== 3'd0) begin errors++; $display("FAIL rr_post_count c=%0d got=%0d exp=0", c, dut.count); end
            if (c == 7) begin
                checks++;
                if (flit_valid_o !== 1'b0 || release_o !== 1'b0) begin
                    errors++; $display("FAIL rr_post_fv_rel got=%b%b exp=00", flit_valid_o, release_o);
                end
                checks++;
                if (2'(dut.state) !== 2'd0) begin errors++; $display("FAIL rr_post_state got=%0d exp=0", 2'(dut.state)); end
            end
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        valid_i     = 1'b0;
        data_i      = '0;
        grant_i     = 1'b0;
        out_ready_i = 1'b0;
        step();
        test_reset();
        test_basic();
        test_route();
        test_fill();
        do_reset();
        test_wrap();
        test_body_idle();
        do_reset();
        test_ready_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
